pipe_hazard_scoreboard: RTL and testbench
=========================================

Name: pipe_hazard_scoreboard

Overview:
- Parametrised successor to the fixed 5-stage hazard-detection and forwarding pair.
- Tracks every in-flight instruction from issue (ID->EX) to retirement in a DEPTH-entry record pipeline, with per-source match logic.
- Produces the load-use stall, bubble and flush controls, plus registered forwarding selects for the EX operand muxes.
- Handles a variable-latency data memory through a wait handshake that freezes the back end.

Parameters:
- DEPTH, 3, number of tracked stages after ID (EX, MEM, WB, ...); 2..8.
- NSRC, 2, number of source operands per instruction (rn, rm, optional third).
- RW, 5, register-index width.
- ZERO_REG, 31, register index hardwired to zero; never tracked, never forwarded.
- LOAD_FWD, 2, first record index at which load data is forwardable; 1..DEPTH-1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_src  in  NSRC*RW  source register indices, src0 in LSBs.
- id_src_used  in  NSRC  per-source "operand actually read".
- id_rd  in  RW  destination index.
- id_regWrite  in  1  instruction writes rd.
- id_memRead  in  1  instruction is a load.
- flush  in  1  branch taken (PCSrc), resolved in record index 1.
- mem_wait  in  1  data memory not ready; back end must hold.
- stall  out  1  hold PC and IF/ID.
- bubble  out  1  zero control bits entering ID/EX.
- fwd_sel  out  NSRC*W  per-source forwarding select for the EX operands, W = clog2(DEPTH+1); 0 = register file, k = record k result.
- busy  out  1  any record valid.

Behaviour:
- Record: rec[k] = {v, rd, wr, ld}; rec[0] = EX, rec[DEPTH-1] = oldest.
- Reset (reset = 0, async): all rec.v = 0, fwd_sel = 0. Outputs stall = 0, bubble = 0 and busy = 0 while reset is held. A reset mid-operation drops all records immediately.
- Match rule: srcmatch(s,k) = id_src_used[s] & rec[k].v & rec[k].wr & (rec[k].rd == src_s) & (src_s != ZERO_REG).
- Load-use hazard: luh = id_valid & OR over s,k of (srcmatch(s,k) & rec[k].ld & k <= LOAD_FWD-2). With default parameters this is a one-cycle stall for a load immediately followed by a consumer.
- stall = luh | mem_wait. bubble = luh & ~mem_wait & ~flush. Both outputs are combinational.
- Advance (posedge, mem_wait = 0):
  - rec[k] <= rec[k-1] for k >= 1.
  - rec[0] <= issue record if id_valid & ~luh & ~flush, else invalid.
  - The issue record's wr bit is cleared when id_rd == ZERO_REG.
- Freeze (mem_wait = 1): all records and fwd_sel hold. flush is ignored during mem_wait. The memory stage holds PCSrc until release.
- Flush (mem_wait = 0): rec[0] and rec[1] invalidate on the next edge, instead of shifting into rec[1] and rec[2]. rec[1] is the branch itself and carries wr = 0. Nothing is issued that cycle.
- Forwarding select:
  - Computed at issue and registered on advance.
  - For each s, take the youngest k in 0..DEPTH-2 with srcmatch(s,k); fwd_sel_s <= k+1 (the position that record occupies next cycle).
  - If there is no match, or only rec[DEPTH-1] matches, fwd_sel_s <= 0. The register file is write-through and returns the retiring value.
  - On bubble or flush, fwd_sel <= 0.
- Youngest wins: with two matches, the lower k is selected.
- busy = OR of rec[k].v.

Optional Feature:
- Macro HDU_PERF_EN adds ports perf_stall_cnt out 32, perf_flush_cnt out 32 and perf_wait_cnt out 32.
  - Counters reset to 0 and wrap at 2^32.
  - Increment on cycles with bubble = 1, on flush accepted (flush & ~mem_wait), and on mem_wait = 1, respectively.
- Without the macro these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- LDUR X1 issued, next ADD X2,X1,X3 in ID -> stall = 1 and bubble = 1 for exactly 1 cycle; ADD then issues with fwd_sel0 = 2.
- ADD X1 then SUB X4,X1,X1 back-to-back -> no stall; SUB in EX sees fwd_sel0 = fwd_sel1 = 1.
- ADD X5 followed by ORR X5 then AND X6,X5,X0 -> fwd_sel0 = 1 (youngest), not 2.
- Load to X31 followed by a consumer of X31 -> no stall, fwd_sel = 0.
- mem_wait held 4 cycles with a load in rec[1] -> stall = 1 for 4 cycles, records and fwd_sel unchanged; flush pulsed during the wait is ignored; a flush accepted after release clears rec[0] and rec[1], with bubble = 0 that cycle.
- reset deasserted-then-asserted mid-stream with 3 valid records -> busy = 0, stall = 0 and fwd_sel = 0 immediately, without waiting for a clock edge; with HDU_PERF_EN defined, the counters read 0.

Source files
------------

// File: rtl/pipe_hazard_scoreboard_if.sv
// Hazard scoreboard port bundle: ID-stage issue info, branch/memory controls
// in, stall/bubble/forwarding controls out.
interface pipe_hazard_scoreboard_if #(
    parameter int DEPTH = 3,
    parameter int NSRC  = 2,
    parameter int RW    = 5
);
    localparam int W = $clog2(DEPTH + 1);

    logic               id_valid;
    logic [NSRC*RW-1:0] id_src;
    logic [NSRC-1:0]    id_src_used;
    logic [RW-1:0]      id_rd;
    logic               id_regWrite;
    logic               id_memRead;
    logic               flush;
    logic               mem_wait;
    logic               stall;
    logic               bubble;
    logic [NSRC*W-1:0]  fwd_sel;
    logic               busy;

    // pipeline front end drives issue info and reads hazard controls
    modport master (
        output id_valid, id_src, id_src_used, id_rd, id_regWrite, id_memRead,
               flush, mem_wait,
        input  stall, bubble, fwd_sel, busy
    );

    // the scoreboard itself
    modport slave (
        input  id_valid, id_src, id_src_used, id_rd, id_regWrite, id_memRead,
               flush, mem_wait,
        output stall, bubble, fwd_sel, busy
    );
endinterface

// File: rtl/pipe_hazard_scoreboard.sv
// Parametrised hazard scoreboard: tracks in-flight instructions from issue to
// retirement, raises load-use stall/bubble and registers per-source forwarding
// selects. mem_wait freezes the whole record pipeline.
// Optional macro HDU_PERF_EN adds stall/flush/wait event counters.
module pipe_hazard_scoreboard #(
    parameter int DEPTH    = 3,
    parameter int NSRC     = 2,
    parameter int RW       = 5,
    parameter int ZERO_REG = 31,
    parameter int LOAD_FWD = 2
) (
    input  logic clk,
    input  logic reset,
    pipe_hazard_scoreboard_if.slave hif
`ifdef HDU_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt,
    output logic [31:0] perf_wait_cnt
`endif
);
    localparam int W = $clog2(DEPTH + 1);
    localparam logic [RW-1:0] ZR = RW'(ZERO_REG);

    typedef struct packed {
        logic          v;
        logic [RW-1:0] rd;
        logic          wr;
        logic          ld;
    } rec_t;

    rec_t [DEPTH-1:0]           rec;
    rec_t                       iss_rec;
    logic [NSRC-1:0][DEPTH-1:0] match;
    logic [NSRC-1:0][W-1:0]     fwd_nxt;
    logic [NSRC-1:0][W-1:0]     fwd_q;
    logic                       luh_any;
    logic                       luh;
    logic                       issue;
    logic                       busy_c;

    // dependency of each source operand on each tracked record
    always_comb begin
        for (int s = 0; s < NSRC; s++) begin
            for (int k = 0; k < DEPTH; k++) begin
                match[s][k] = hif.id_src_used[s] & rec[k].v & rec[k].wr
                            & (rec[k].rd == hif.id_src[s*RW +: RW])
                            & (hif.id_src[s*RW +: RW] != ZR);
            end
        end
    end

    // load-use: consumer of a load whose data is not yet forwardable
    always_comb begin
        luh_any = 1'b0;
        for (int s = 0; s < NSRC; s++) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (k <= LOAD_FWD - 2 && match[s][k] && rec[k].ld)
                    luh_any = 1'b1;
            end
        end
    end

    // forwarding source per operand: scan oldest-to-youngest so the youngest
    // match overwrites; the oldest record retires into the write-through RF
    always_comb begin
        for (int s = 0; s < NSRC; s++) begin
            fwd_nxt[s] = '0;
            for (int k = DEPTH - 2; k >= 0; k--) begin
                if (match[s][k])
                    fwd_nxt[s] = W'(k + 1);
            end
        end
    end

    // record entering EX; writes to the zero register are never tracked
    always_comb begin
        iss_rec.v  = issue;
        iss_rec.rd = hif.id_rd;
        iss_rec.wr = hif.id_regWrite & (hif.id_rd != ZR);
        iss_rec.ld = hif.id_memRead;
    end

    // any record still in flight
    always_comb begin
        busy_c = 1'b0;
        for (int k = 0; k < DEPTH; k++)
            busy_c = busy_c | rec[k].v;
    end

    assign luh         = hif.id_valid & luh_any;
    assign issue       = hif.id_valid & ~luh & ~hif.flush;
    assign hif.stall   = reset & (luh | hif.mem_wait);
    assign hif.bubble  = reset & luh & ~hif.mem_wait & ~hif.flush;
    assign hif.fwd_sel = fwd_q;
    assign hif.busy    = busy_c;

    // record shift and forwarding-select register; frozen while memory waits,
    // a taken branch kills the wrong-path slot and the branch slot
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rec   <= '0;
            fwd_q <= '0;
        end else if (!hif.mem_wait) begin
            rec[0] <= iss_rec;
            for (int k = 1; k < DEPTH; k++)
                rec[k] <= (hif.flush && k <= 2) ? '0 : rec[k-1];
            fwd_q <= issue ? fwd_nxt : '0;
        end
    end

`ifdef HDU_PERF_EN
    // free-running event counters, wrap naturally at 2^32
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
            perf_wait_cnt  <= '0;
        end else begin
            if (hif.bubble)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (hif.flush && !hif.mem_wait)
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            if (hif.mem_wait)
                perf_wait_cnt <= perf_wait_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Scoreboard bench for pipe_hazard_scoreboard (default parameters): the driver
// pushes hand-computed per-cycle expectations, a negedge monitor pops and
// compares. Define HDU_PERF_EN to also check the event counters.
module tb_pipe_hazard_scoreboard;
    localparam int W = 2;

    typedef struct {
        string nm;
        bit    stall;
        bit    bubble;
        bit    busy;
        int    f0;
        int    f1;
        bit    pchk;
        int    ps;
        int    pf;
        int    pw;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    pipe_hazard_scoreboard_if #(.DEPTH(3), .NSRC(2), .RW(5)) hif ();

`ifdef HDU_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
    logic [31:0] perf_wait_cnt;
`endif

    pipe_hazard_scoreboard #(
        .DEPTH(3), .NSRC(2), .RW(5), .ZERO_REG(31), .LOAD_FWD(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hif   (hif)
`ifdef HDU_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt),
        .perf_wait_cnt  (perf_wait_cnt)
`endif
    );

    function automatic void chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endfunction

    // apply one cycle of ID/control inputs and queue that cycle's expectation
    task automatic drive(input string nm, input bit v, input int s0, input int s1,
                         input bit [1:0] used, input int rd, input bit wr, input bit ld,
                         input bit fl, input bit mw,
                         input bit es, input bit eb, input int f0, input int f1,
                         input bit ebusy);
        exp_t e;
        @(posedge clk);
        #1;
        hif.id_valid    = v;
        hif.id_src      = {5'(s1), 5'(s0)};
        hif.id_src_used = used;
        hif.id_rd       = 5'(rd);
        hif.id_regWrite = wr;
        hif.id_memRead  = ld;
        hif.flush       = fl;
        hif.mem_wait    = mw;
        e.nm = nm; e.stall = es; e.bubble = eb; e.busy = ebusy;
        e.f0 = f0; e.f1 = f1; e.pchk = 1'b0; e.ps = 0; e.pf = 0; e.pw = 0;
        q.push_back(e);
    endtask

    task automatic idle(input string nm, input bit mw, input bit es,
                        input int f0, input int f1, input bit ebusy);
        drive(nm, 0, 0, 0, 2'b00, 0, 0, 0, 0, mw, es, 0, f0, f1, ebusy);
    endtask

    task automatic want_perf(input int ps, input int pf, input int pw);
        q[q.size()-1].pchk = 1'b1;
        q[q.size()-1].ps = ps;
        q[q.size()-1].pf = pf;
        q[q.size()-1].pw = pw;
    endtask

    // monitor: compare outputs mid-cycle against the queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk({e.nm, ".stall"},  int'(hif.stall),        int'(e.stall));
            chk({e.nm, ".bubble"}, int'(hif.bubble),       int'(e.bubble));
            chk({e.nm, ".busy"},   int'(hif.busy),         int'(e.busy));
            chk({e.nm, ".fwd0"},   int'(hif.fwd_sel[1:0]), e.f0);
            chk({e.nm, ".fwd1"},   int'(hif.fwd_sel[3:2]), e.f1);
`ifdef HDU_PERF_EN
            if (e.pchk) begin
                chk({e.nm, ".perf_stall"}, int'(perf_stall_cnt), e.ps);
                chk({e.nm, ".perf_flush"}, int'(perf_flush_cnt), e.pf);
                chk({e.nm, ".perf_wait"},  int'(perf_wait_cnt),  e.pw);
            end
`endif
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        hif.id_valid = 0; hif.id_src = '0; hif.id_src_used = '0; hif.id_rd = '0;
        hif.id_regWrite = 0; hif.id_memRead = 0; hif.flush = 0; hif.mem_wait = 1;

        // reset held with mem_wait high: controls must stay quiet
        idle("rst", 1, 0, 0, 0, 0);
        want_perf(0, 0, 0);
        @(negedge clk);
        #1;
        hif.mem_wait = 0;
        reset = 1'b1;

        //     name         v  s0  s1  used  rd  wr ld fl mw   st bu f0 f1 busy
        // load-use: one bubble, then the consumer issues forwarding from slot 2
        drive("ld_x1",      1, 2,  0,  2'b01, 1, 1, 1, 0, 0,  0, 0, 0, 0, 0);
        drive("lu_stall",   1, 1,  3,  2'b11, 2, 1, 0, 0, 0,  1, 1, 0, 0, 1);
        drive("lu_issue",   1, 1,  3,  2'b11, 2, 1, 0, 0, 0,  0, 0, 0, 0, 1);
        idle ("lu_fwd",     0, 0, 2, 0, 1);
        // back-to-back ALU dependency on both sources
        drive("add_x1",     1, 7,  8,  2'b11, 1, 1, 0, 0, 0,  0, 0, 0, 0, 1);
        drive("sub_x4",     1, 1,  1,  2'b11, 4, 1, 0, 0, 0,  0, 0, 0, 0, 1);
        idle ("b2b_fwd",    0, 0, 1, 1, 1);
        // two writers of X5 in flight: youngest wins
        drive("add_x5",     1, 9,  10, 2'b11, 5, 1, 0, 0, 0,  0, 0, 0, 0, 1);
        drive("orr_x5",     1, 11, 12, 2'b11, 5, 1, 0, 0, 0,  0, 0, 0, 0, 1);
        drive("and_x6",     1, 5,  0,  2'b11, 6, 1, 0, 0, 0,  0, 0, 0, 0, 1);
        idle ("youngest",   0, 0, 1, 0, 1);
        // load into the zero register is never a hazard nor a forward source
        drive("ld_x31",     1, 2,  0,  2'b01, 31, 1, 1, 0, 0, 0, 0, 0, 0, 1);
        drive("use_x31",    1, 31, 31, 2'b11, 7, 1, 0, 0, 0,  0, 0, 0, 0, 1);
        drive("x31_fwd",    1, 20, 21, 2'b11, 13, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        // build state: load X9 lands in rec[1], fwd_sel0 = 2 at the wait
        drive("ld_x9",      1, 13, 0,  2'b01, 9, 1, 1, 0, 0,  0, 0, 0, 0, 1);
        drive("add_x14",    1, 13, 22, 2'b11, 14, 1, 0, 0, 0, 0, 0, 1, 0, 1);
        // memory wait 4 cycles, flush pulse inside is ignored
        drive("wait0",      1, 9,  0,  2'b01, 15, 1, 1, 0, 1, 1, 0, 2, 0, 1);
        drive("wait1",      1, 9,  0,  2'b01, 15, 1, 1, 0, 1, 1, 0, 2, 0, 1);
        drive("wait2",      1, 9,  0,  2'b01, 15, 1, 1, 1, 1, 1, 0, 2, 0, 1);
        drive("wait3",      1, 9,  0,  2'b01, 15, 1, 1, 0, 1, 1, 0, 2, 0, 1);
        drive("release",    1, 9,  0,  2'b01, 15, 1, 1, 0, 0, 0, 0, 2, 0, 1);
        // flush with a load-use pending: stall but no bubble, pipe empties
        drive("flush",      1, 15, 15, 2'b11, 16, 1, 0, 1, 0, 1, 0, 2, 0, 1);
        idle ("flushed",    0, 0, 0, 0, 0);
        // three valid records, then an asynchronous mid-stream reset
        drive("add_x1b",    1, 20, 21, 2'b11, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0);
        drive("add_x2",     1, 1,  21, 2'b11, 2, 1, 0, 0, 0,  0, 0, 0, 0, 1);
        drive("add_x3",     1, 2,  1,  2'b11, 3, 1, 0, 0, 0,  0, 0, 1, 0, 1);
        idle ("hold3",      1, 1, 1, 2, 1);
        want_perf(1, 1, 4);
        idle ("async_rst",  1, 0, 0, 0, 0);
        reset = 1'b0;
        want_perf(0, 0, 0);
        @(negedge clk);
        #1;
        hif.mem_wait = 0;
        reset = 1'b1;
        idle ("post_rst",   0, 0, 0, 0, 0);
        want_perf(0, 0, 0);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
